clk_mux_ctrl: RTL

CLK_MUX_CTRL -- requirements
Module: clk_mux_ctrl

---
 rtl/clk_mux_ctrl_pkg.sv | 19 +
 rtl/clk_mux_ctrl_cnt.sv | 33 +++
 rtl/clk_mux_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/clk_mux_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clk_mux_ctrl_pkg
// Brief    : Shared FSM state encoding and counter width for clk_mux_ctrl.
// Revision : 1.0
// ============================================================================
package clk_mux_ctrl_pkg;

    localparam int unsigned c_cnt_width = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GATE   = 2'd1,
        ST_SWITCH = 2'd2,
        ST_SETTLE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/clk_mux_ctrl_cnt.sv
`default_nettype none
// ============================================================================
// Module   : clk_mux_ctrl_cnt
// Brief    : Loadable down-counter that stops at zero (never wraps).
// Revision : 1.0
// ============================================================================
module clk_mux_ctrl_cnt
    import clk_mux_ctrl_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   load_i,
    input  logic [c_cnt_width-1:0] load_val_i,
    input  logic                   en_i,
    output logic                   zero_o
);

    logic [c_cnt_width-1:0] r_count;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count <= '0;
        end else if (load_i) begin
            r_count <= load_val_i;
        end else if (en_i && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign zero_o = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/clk_mux_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clk_mux_ctrl
// Brief    : Glitch-safe clock mux select sequencer: gate, switch, settle.
// Revision : 1.0
// ============================================================================
module clk_mux_ctrl
    import clk_mux_ctrl_pkg::*;
#(
    parameter int unsigned GATE_CYCLES   = 4,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter logic        DEFAULT_SEL   = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sel_req_i,
    input  logic req_valid_i,
    output logic req_ready_o,
    output logic clk_sel_o,
    output logic clk_en_o,
    output logic busy_o,
    output logic done_o
);

    // Counter reaches zero on the last cycle of the phase, hence the -1.
    localparam logic [c_cnt_width-1:0] c_gate_load   = c_cnt_width'(GATE_CYCLES - 1);
    localparam logic [c_cnt_width-1:0] c_settle_load = c_cnt_width'(SETTLE_CYCLES - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_sel;
    logic                   r_en;
    logic                   r_done;
    logic                   r_sel_latched;
    logic                   w_sel_nxt;
    logic                   w_en_nxt;
    logic                   w_done_nxt;
    logic                   w_sel_latched_nxt;
    logic                   w_cnt_load;
    logic [c_cnt_width-1:0] w_cnt_load_val;
    logic                   w_cnt_en;
    logic                   w_cnt_zero;

    clk_mux_ctrl_cnt u_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (w_cnt_load),
        .load_val_i (w_cnt_load_val),
        .en_i       (w_cnt_en),
        .zero_o     (w_cnt_zero)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= ST_IDLE;
            r_sel         <= DEFAULT_SEL;
            r_en          <= 1'b1;
            r_done        <= 1'b0;
            r_sel_latched <= DEFAULT_SEL;
        end else begin
            r_state       <= w_state_nxt;
            r_sel         <= w_sel_nxt;
            r_en          <= w_en_nxt;
            r_done        <= w_done_nxt;
            r_sel_latched <= w_sel_latched_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_sel_nxt         = r_sel;
        w_en_nxt          = r_en;
        w_done_nxt        = 1'b0;
        w_sel_latched_nxt = r_sel_latched;
        w_cnt_load        = 1'b0;
        w_cnt_load_val    = '0;
        w_cnt_en          = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (req_valid_i) begin
                    if (sel_req_i == r_sel) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_sel_latched_nxt = sel_req_i;
                        w_en_nxt          = 1'b0;
                        w_cnt_load        = 1'b1;
                        w_cnt_load_val    = c_gate_load;
                        w_state_nxt       = ST_GATE;
                    end
                end
            end
            ST_GATE: begin
                w_cnt_en = 1'b1;
                // Select flips entering SWITCH, while the enable is still low.
                if (w_cnt_zero) begin
                    w_sel_nxt   = r_sel_latched;
                    w_state_nxt = ST_SWITCH;
                end
            end
            ST_SWITCH: begin
                w_cnt_load     = 1'b1;
                w_cnt_load_val = c_settle_load;
                w_state_nxt    = ST_SETTLE;
            end
            ST_SETTLE: begin
                w_cnt_en = 1'b1;
                if (w_cnt_zero) begin
                    w_en_nxt    = 1'b1;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign req_ready_o = (r_state == ST_IDLE);
    assign busy_o      = (r_state != ST_IDLE);
    assign clk_sel_o   = r_sel;
    assign clk_en_o    = r_en;
    assign done_o      = r_done;

endmodule
`default_nettype wire
